// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the router output-channel packet FIFO.
// Contents:
//   - clog2 helper used to size pointers and the occupancy port.
//   - Header field positions: the payload length sits in the top LEN bits of a
//     header word, and the destination address sits in bits [1:0].
//   - Tagged storage entry {sop, data} for the default 8-bit channel width.
package router_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int HDR_LEN_W    = 6;
  localparam int HDR_LEN_MSB  = DEF_DATA_W - 1;
  localparam int HDR_DEST_MSB = 1;
  localparam int HDR_DEST_LSB = 0;

  typedef struct packed {
    logic                  sop;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/router_pkt_fifo_if.sv
// router_pkt_fifo_if
// Handshake/status bundle between a router write/read client and the packet FIFO.
// Modports:
//   master : client side (drives wr_en, sop_in, din, rd_en; observes all status/data)
//   slave  : FIFO side (the mirror image)
// Signals: wr_en, sop_in, din[DATA_W], rd_en, full, almost_full, empty,
//          level[AW+1], dout[DATA_W], dout_valid, dout_sop, pkt_busy,
//          overflow, underflow, frame_err, parity_err.
interface router_pkt_fifo_if
  import router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);

  localparam int AW = clog2(DEPTH);

  logic              wr_en;
  logic              sop_in;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic              full;
  logic              almost_full;
  logic              empty;
  logic [AW:0]       level;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_sop;
  logic              pkt_busy;
  logic              overflow;
  logic              underflow;
  logic              frame_err;
  logic              parity_err;

  modport master (
    output wr_en, sop_in, din, rd_en,
    input  full, almost_full, empty, level, dout, dout_valid, dout_sop,
           pkt_busy, overflow, underflow, frame_err, parity_err
  );

  modport slave (
    input  wr_en, sop_in, din, rd_en,
    output full, almost_full, empty, level, dout, dout_valid, dout_sop,
           pkt_busy, overflow, underflow, frame_err, parity_err
  );

endinterface

// File: rtl/router_fifo_mem.sv
// router_fifo_mem
// DEPTH x WIDTH storage, one write port and one registered read port, no reset.
// The read register is write-first: when the same edge writes the address being
// read, the new word is captured, so a word written into an empty FIFO is
// visible on o_rdata right after its write edge.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address, captured every edge
//   o_rdata  registered read data
module router_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage array write.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read with write-first forwarding.
  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo
// Packet-aware FIFO for one router output channel. Words carry a start-of-packet
// tag; on the read side a remaining-word count tracks the packet being drained
// (header len + 1 words follow the header, the last being a parity word).
// Optional feature macro: ROUTER_FIFO_PARITY_EN enables the running-XOR parity
// check of each packet; without it parity_err is tied low.
// Ports:
//   clk         clock
//   reset       synchronous, active-low full reset
//   soft_reset  synchronous, active-high channel flush (dout keeps its value)
//   bus         router_pkt_fifo_if.slave: write/read handshake, status, errors
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = 16,
  parameter int LEN_W     = HDR_LEN_W,
  parameter int AF_THRESH = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               soft_reset,
  router_pkt_fifo_if.slave   bus
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]    AF_LVL  = (AW+1)'(AF_THRESH);
  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [AW:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       w_rd_ptr_nxt;
  logic [AW:0]       w_level;
  logic              w_full;
  logic              w_empty;
  logic              w_run;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W:0]   w_head;
  logic              w_head_sop;
  logic [DATA_W-1:0] w_head_data;
  logic [LEN_W:0]    w_hdr_cnt;

  logic [LEN_W:0]    r_cnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_dout_sop;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_frame_err;

  assign w_run    = reset && !soft_reset;
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && !w_empty;

  assign w_head_sop  = w_head[DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];
  // Header len counts payload words; the trailing parity word adds one more.
  assign w_hdr_cnt   = {1'b0, w_head_data[DATA_W-1 -: LEN_W]} + CNT_ONE;

  // Read pointer after this edge; the memory prefetches that entry so the
  // head word is always waiting on w_head when a read is accepted.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    if (!w_run) begin
      w_rd_ptr_nxt = '0;
    end else if (w_rd_acc) begin
      w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
  end

  router_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_run && w_wr_acc),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata ({bus.sop_in, bus.din}),
    .i_raddr (w_rd_ptr_nxt[AW-1:0]),
    .o_rdata (w_head)
  );

  // Write/read pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (soft_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  // Read data, remaining-word count and framing check.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_sop   <= 1'b0;
      r_cnt        <= '0;
      r_frame_err  <= 1'b0;
    end else if (soft_reset) begin
      r_dout       <= r_dout;
      r_dout_valid <= 1'b0;
      r_dout_sop   <= 1'b0;
      r_cnt        <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_acc;
      r_frame_err  <= 1'b0;
      if (w_rd_acc) begin
        r_dout     <= w_head_data;
        r_dout_sop <= w_head_sop;
        if (w_head_sop) begin
          // A header arriving before the previous packet drained means truncation.
          r_cnt       <= w_hdr_cnt;
          r_frame_err <= (r_cnt != '0);
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - CNT_ONE;
        end else begin
          // Payload word with no open packet.
          r_frame_err <= 1'b1;
        end
      end else begin
        r_dout     <= r_dout;
        r_dout_sop <= r_dout_sop;
      end
    end
  end

  // Overflow/underflow request pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (soft_reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= bus.wr_en && w_full;
      r_underflow <= bus.rd_en && w_empty;
    end
  end

`ifdef ROUTER_FIFO_PARITY_EN
  logic [DATA_W-1:0] r_par;
  logic              r_parity_err;

  // Running XOR of header and payload, compared against the parity word
  // (the word read while one word of the packet remains).
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_par        <= '0;
      r_parity_err <= 1'b0;
    end else if (soft_reset) begin
      r_par        <= '0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      if (w_rd_acc && w_head_sop) begin
        r_par <= w_head_data;
      end else if (w_rd_acc && (r_cnt == CNT_ONE)) begin
        r_parity_err <= (w_head_data != r_par);
      end else if (w_rd_acc && (r_cnt != '0)) begin
        r_par <= r_par ^ w_head_data;
      end else begin
        r_par <= r_par;
      end
    end
  end

  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.level       = w_level;
  assign bus.almost_full = (w_level >= AF_LVL);
  assign bus.dout        = r_dout;
  assign bus.dout_valid  = r_dout_valid;
  assign bus.dout_sop    = r_dout_sop;
  assign bus.pkt_busy    = (r_cnt != '0);
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
  assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo
// Queue-based reference model of the packet FIFO, checked against the DUT on
// every cycle, plus directed scenarios with hand-computed expectations and a
// randomized phase (random traffic, well-formed packets, flushes and resets).
module tb_router_pkt_fifo;
  import router_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;
`ifdef ROUTER_FIFO_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic soft_reset = 1'b0;
  always #5 clk = ~clk;

  router_pkt_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  router_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .LEN_W(6), .AF_THRESH(AFT)) dut (
    .clk        (clk),
    .reset      (reset),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  fifo_entry_t q[$];
  int          m_cnt = 0;
  logic [7:0]  m_par = 8'h00;
  logic [7:0]  m_dout = 8'h00;
  logic        m_dv = 1'b0, m_dsop = 1'b0, m_ov = 1'b0, m_un = 1'b0, m_fe = 1'b0, m_pe = 1'b0;
  bit          m_ok = 1'b0;

  always @(posedge clk) begin
    fifo_entry_t e;
    bit was_full, was_empty;
    if (!reset) begin
      q.delete(); m_cnt = 0; m_par = 8'h00; m_dout = 8'h00;
      m_dv = 0; m_dsop = 0; m_ov = 0; m_un = 0; m_fe = 0; m_pe = 0;
      m_ok = 1'b1;
    end else if (soft_reset) begin
      q.delete(); m_cnt = 0; m_par = 8'h00;
      m_dv = 0; m_dsop = 0; m_ov = 0; m_un = 0; m_fe = 0; m_pe = 0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ov = bus.wr_en && was_full;
      m_un = bus.rd_en && was_empty;
      m_dv = 0; m_fe = 0; m_pe = 0;
      if (bus.rd_en && !was_empty) begin
        e = q.pop_front();
        m_dout = e.data; m_dsop = e.sop; m_dv = 1;
        if (e.sop) begin
          m_fe  = (m_cnt != 0);
          m_cnt = int'(e.data >> 2) + 1;
          m_par = e.data;
        end else if (m_cnt == 1) begin
          m_pe  = PAR_ON && (e.data != m_par);
          m_cnt = 0;
        end else if (m_cnt > 1) begin
          m_par = m_par ^ e.data;
          m_cnt = m_cnt - 1;
        end else begin
          m_fe = 1;
        end
      end
      if (bus.wr_en && !was_full) begin
        e.sop = bus.sop_in; e.data = bus.din;
        q.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      check("m_level",     32'(bus.level),       32'(q.size()));
      check("m_full",      32'(bus.full),        32'(q.size() == DEPTH));
      check("m_empty",     32'(bus.empty),       32'(q.size() == 0));
      check("m_afull",     32'(bus.almost_full), 32'(q.size() >= AFT));
      check("m_dout",      32'(bus.dout),        32'(m_dout));
      check("m_dvalid",    32'(bus.dout_valid),  32'(m_dv));
      check("m_dsop",      32'(bus.dout_sop),    32'(m_dsop));
      check("m_busy",      32'(bus.pkt_busy),    32'(m_cnt != 0));
      check("m_overflow",  32'(bus.overflow),    32'(m_ov));
      check("m_underflow", 32'(bus.underflow),   32'(m_un));
      check("m_frame",     32'(bus.frame_err),   32'(m_fe));
      check("m_parity",    32'(bus.parity_err),  32'(m_pe));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit w, input bit s, input logic [7:0] d, input bit r);
    bus.wr_en = w; bus.sop_in = s; bus.din = d; bus.rd_en = r;
    @(negedge clk);
  endtask

  task automatic wr(input bit s, input logic [7:0] d);
    cyc(1'b1, s, d, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] pkt [5];
  logic [7:0] hdr, par, d;
  int         len;

  initial begin
    bus.wr_en = 1'b0; bus.sop_in = 1'b0; bus.din = 8'h00; bus.rd_en = 1'b0;
    @(negedge clk);

    // Reset state.
    reset = 1'b0; idle(); idle();
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_dout",  32'(bus.dout),  32'd0);
    check("rst_full",  32'(bus.full),  32'd0);
    reset = 1'b1; idle();

    // Fill to full, then overflow.
    for (int k = 1; k <= DEPTH; k++) begin
      wr(1'b0, 8'(k));
      check("fill_afull", 32'(bus.almost_full), 32'(k >= AFT));
    end
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_level", 32'(bus.level), 32'd16);
    wr(1'b0, 8'hEE);
    check("ovf_pulse", 32'(bus.overflow), 32'd1);
    check("ovf_level", 32'(bus.level),    32'd16);
    // Drain: words without a header are orphans.
    rd();
    check("orphan_fe",   32'(bus.frame_err), 32'd1);
    check("orphan_busy", 32'(bus.pkt_busy),  32'd0);
    check("orphan_dout", 32'(bus.dout),      32'd1);
    for (int k = 1; k < DEPTH; k++) rd();
    rd();
    check("udf_pulse", 32'(bus.underflow), 32'd1);

    // Good packet: header 0x0C (len 3), parity = 0x0C^0x11^0x22^0x33 = 0x0C.
    pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h0C;
    for (int i = 0; i < 5; i++) wr(i == 0, pkt[i]);
    for (int i = 0; i < 5; i++) begin
      rd();
      check("pkt_dout",  32'(bus.dout),       32'(pkt[i]));
      check("pkt_sop",   32'(bus.dout_sop),   32'(i == 0));
      check("pkt_busy",  32'(bus.pkt_busy),   32'(i < 4));
      check("pkt_dv",    32'(bus.dout_valid), 32'd1);
      check("pkt_fe",    32'(bus.frame_err),  32'd0);
      check("pkt_perr",  32'(bus.parity_err), 32'd0);
    end
    idle();
    check("pkt_dv_off", 32'(bus.dout_valid), 32'd0);

    // Same packet with a bad parity word.
    pkt[4] = 8'hFF;
    for (int i = 0; i < 5; i++) wr(i == 0, pkt[i]);
    for (int i = 0; i < 5; i++) rd();
    check("bad_par", 32'(bus.parity_err), 32'(PAR_ON));

    // Truncated packet: new header while count is 2.
    wr(1'b1, 8'h0C); wr(1'b0, 8'h11); wr(1'b0, 8'h22);
    wr(1'b1, 8'h08); wr(1'b0, 8'h01); wr(1'b0, 8'h02); wr(1'b0, 8'h0B);
    rd(); rd(); rd();
    check("trunc_busy", 32'(bus.pkt_busy), 32'd1);
    rd();
    check("trunc_fe",   32'(bus.frame_err), 32'd1);
    check("trunc_dout", 32'(bus.dout),      32'h08);
    rd(); rd(); rd();
    check("trunc_end_busy", 32'(bus.pkt_busy),   32'd0);
    check("trunc_end_perr", 32'(bus.parity_err), 32'd0);

    // Wrap-around with steady level 7.
    for (int i = 0; i < 10; i++) wr(1'b0, 8'($urandom));
    rd(); rd(); rd();
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 8'($urandom), 1'b1);
      check("wrap_level", 32'(bus.level), 32'd7);
    end
    soft_reset = 1'b1; idle(); soft_reset = 1'b0;

    // Flush mid-packet (count 3, level 5), then full reset.
    wr(1'b1, 8'h0C); wr(1'b0, 8'h11); wr(1'b0, 8'h22); wr(1'b0, 8'h33);
    wr(1'b0, 8'h0C); wr(1'b0, 8'h40); wr(1'b0, 8'h41);
    rd(); rd();
    check("pre_sr_level", 32'(bus.level),    32'd5);
    check("pre_sr_busy",  32'(bus.pkt_busy), 32'd1);
    soft_reset = 1'b1; idle(); soft_reset = 1'b0;
    check("sr_empty", 32'(bus.empty),      32'd1);
    check("sr_level", 32'(bus.level),      32'd0);
    check("sr_busy",  32'(bus.pkt_busy),   32'd0);
    check("sr_dv",    32'(bus.dout_valid), 32'd0);
    check("sr_dout",  32'(bus.dout),       32'h11);
    reset = 1'b0; idle(); reset = 1'b1;
    check("hr_dout",  32'(bus.dout),       32'd0);

    // Well-formed random packets with random read pressure.
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(0, 5);
      hdr = {6'(len), 2'($urandom)};
      par = hdr;
      cyc(1'b1, 1'b1, hdr, $urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom);
        par = par ^ d;
        cyc(1'b1, 1'b0, d, $urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 3) == 0) par = ~par;
      cyc(1'b1, 1'b0, par, $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 20; i++) rd();

    // Unconstrained random traffic with occasional flush/reset.
    for (int c = 0; c < 3000; c++) begin
      soft_reset = ($urandom_range(0, 99) == 0);
      reset      = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 4) == 0,
          8'($urandom), $urandom_range(0, 99) < 50);
    end
    soft_reset = 1'b0; reset = 1'b1;
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
